// File: rtl/marker_tracker.sv
// Per-frame temporal filter for the four detector targets: snapshot at frame end,
// jump rejection, shift-based smoothing, lock tracking and an atomic publish of results.
module marker_tracker #(
    parameter int SCREEN_WIDTH  = 1280,
    parameter int SCREEN_HEIGHT = 720,
    parameter int ALPHA_SHIFT   = 2,
    parameter int JUMP_THRES    = 64,
    parameter int MAX_MISS      = 8,
    localparam int XW = $clog2(SCREEN_WIDTH) + 1,
    localparam int YW = $clog2(SCREEN_HEIGHT) + 1
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [XW-1:0]   hcount_in,
    input  logic [YW-1:0]   vcount_in,
    input  logic [4*XW-1:0] x_in,
    input  logic [4*YW-1:0] y_in,
    input  logic [4*YW-1:0] d_in,
    input  logic [3:0]      valid_in,
    output logic [4*XW-1:0] x_out,
    output logic [4*YW-1:0] y_out,
    output logic [4*YW-1:0] d_out,
    output logic [3:0]      locked_out,
    output logic            update_out,
    output logic            busy_out,
    output logic [1:0]      state_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UPD  = 2'd1,
        S_PUB  = 2'd2
    } state_t;

    localparam int LW = $clog2(MAX_MISS + 1);
    localparam logic [XW-1:0] H_LAST    = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] V_LAST    = YW'(SCREEN_HEIGHT - 1);
    localparam logic [XW:0]   JX        = (XW + 1)'(JUMP_THRES);
    localparam logic [YW:0]   JY        = (YW + 1)'(JUMP_THRES);
    localparam logic [LW-1:0] MISS_LAST = LW'(MAX_MISS - 1);

    state_t        state;
    logic [1:0]    idx;

    logic [XW-1:0] snap_x [4];
    logic [YW-1:0] snap_y [4];
    logic [YW-1:0] snap_d [4];
    logic [3:0]    snap_v;

    logic [XW-1:0] est_x [4];
    logic [YW-1:0] est_y [4];
    logic [YW-1:0] est_d [4];
    logic [LW-1:0] lost_cnt [4];
    logic [3:0]    locked;

    logic frame_end;
    assign frame_end = (hcount_in == H_LAST) && (vcount_in == V_LAST);

    // update_out is a single-cycle strobe; x/y/d/locked_out are stable from that cycle on
    assign busy_out  = (state != S_IDLE);
    assign state_out = state;

    logic signed [XW:0] dx, sx;
    logic signed [YW:0] dy, sy, dd, sd;
    logic [XW:0]        adx;
    logic [YW:0]        ady;
    logic [XW-1:0]      nx;
    logic [YW-1:0]      ny, nd;
    logic               meas_v;
    logic               jump_ok;

    // Differences are one bit wider than the field, so the shifted step always fits back.
    always_comb begin
        meas_v  = snap_v[~idx];  // detector packs target 0 in the top bit
        dx      = $signed({1'b0, snap_x[idx]}) - $signed({1'b0, est_x[idx]});
        dy      = $signed({1'b0, snap_y[idx]}) - $signed({1'b0, est_y[idx]});
        dd      = $signed({1'b0, snap_d[idx]}) - $signed({1'b0, est_d[idx]});
        sx      = dx >>> ALPHA_SHIFT;
        sy      = dy >>> ALPHA_SHIFT;
        sd      = dd >>> ALPHA_SHIFT;
        adx     = dx[XW] ? $unsigned(-dx) : $unsigned(dx);
        ady     = dy[YW] ? $unsigned(-dy) : $unsigned(dy);
        nx      = est_x[idx] + sx[XW-1:0];
        ny      = est_y[idx] + sy[YW-1:0];
        nd      = est_d[idx] + sd[YW-1:0];
        jump_ok = (adx <= JX) && (ady <= JY);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= S_IDLE;
            idx        <= '0;
            snap_v     <= '0;
            locked     <= '0;
            x_out      <= '0;
            y_out      <= '0;
            d_out      <= '0;
            locked_out <= '0;
            update_out <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap_x[i]   <= '0;
                snap_y[i]   <= '0;
                snap_d[i]   <= '0;
                est_x[i]    <= '0;
                est_y[i]    <= '0;
                est_d[i]    <= '0;
                lost_cnt[i] <= '0;
            end
        end else begin
            update_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_end) begin
                        for (int i = 0; i < 4; i++) begin
                            snap_x[i] <= x_in[i*XW +: XW];
                            snap_y[i] <= y_in[i*YW +: YW];
                            snap_d[i] <= d_in[i*YW +: YW];
                        end
                        snap_v <= valid_in;
                        idx    <= '0;
                        state  <= S_UPD;
                    end
                end
                S_UPD: begin
                    if (locked[idx]) begin
                        if (meas_v && jump_ok) begin
                            est_x[idx]    <= nx;
                            est_y[idx]    <= ny;
                            est_d[idx]    <= nd;
                            lost_cnt[idx] <= '0;
                        end else if (lost_cnt[idx] >= MISS_LAST) begin
                            // lock dropped; the estimate stays on the outputs
                            locked[idx]   <= 1'b0;
                            lost_cnt[idx] <= '0;
                        end else begin
                            lost_cnt[idx] <= lost_cnt[idx] + 1'b1;
                        end
                    end else if (meas_v) begin
                        est_x[idx]    <= snap_x[idx];
                        est_y[idx]    <= snap_y[idx];
                        est_d[idx]    <= snap_d[idx];
                        locked[idx]   <= 1'b1;
                        lost_cnt[idx] <= '0;
                    end
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= S_PUB;
                    end
                end
                S_PUB: begin
                    for (int i = 0; i < 4; i++) begin
                        x_out[i*XW +: XW] <= est_x[i];
                        y_out[i*YW +: YW] <= est_y[i];
                        d_out[i*YW +: YW] <= est_d[i];
                    end
                    locked_out <= locked;
                    update_out <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_marker_tracker.sv
// Directed bench for marker_tracker: acquisition, smoothing, jump rejection,
// lock loss, target ordering, ignored mid-update frame end and mid-frame reset.
module tb_marker_tracker;

    localparam int XW = 12;
    localparam int YW = 11;
    localparam logic [XW-1:0] H_LAST = 12'd1279;
    localparam logic [YW-1:0] V_LAST = 11'd719;

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic [XW-1:0]   hcount_in;
    logic [YW-1:0]   vcount_in;
    logic [4*XW-1:0] x_in;
    logic [4*YW-1:0] y_in;
    logic [4*YW-1:0] d_in;
    logic [3:0]      valid_in;
    logic [4*XW-1:0] x_out;
    logic [4*YW-1:0] y_out;
    logic [4*YW-1:0] d_out;
    logic [3:0]      locked_out;
    logic            update_out;
    logic            busy_out;
    logic [1:0]      state_out;

    int n_checks = 0;
    int n_pass   = 0;
    int lat, pulses;

    marker_tracker dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .d_in       (d_in),
        .valid_in   (valid_in),
        .x_out      (x_out),
        .y_out      (y_out),
        .d_out      (d_out),
        .locked_out (locked_out),
        .update_out (update_out),
        .busy_out   (busy_out),
        .state_out  (state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [4*XW-1:0] px(input int t0, input int t1, input int t2, input int t3);
        return {XW'(t3), XW'(t2), XW'(t1), XW'(t0)};
    endfunction

    function automatic logic [4*YW-1:0] py(input int t0, input int t1, input int t2, input int t3);
        return {YW'(t3), YW'(t2), YW'(t1), YW'(t0)};
    endfunction

    // Present a frame end in cycle C, then scramble inputs; optionally raise a second
    // frame end during C+3. Reports the cycle of the first update pulse and the pulse count.
    task automatic run_frame(input logic [4*XW-1:0] xv, input logic [4*YW-1:0] yv,
                             input logic [4*YW-1:0] dv, input logic [3:0] vv,
                             input bit glitch, output int lat_o, output int pulses_o);
        @(negedge clk_in);
        x_in = xv; y_in = yv; d_in = dv; valid_in = vv;
        hcount_in = H_LAST; vcount_in = V_LAST;
        lat_o = 0; pulses_o = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                hcount_in = '0; vcount_in = '0;
                x_in = {4{12'd1000}}; y_in = {4{11'd700}}; d_in = {4{11'd700}};
                valid_in = 4'b1111;
            end
            if (glitch && k == 3) begin hcount_in = H_LAST; vcount_in = V_LAST; end
            if (glitch && k == 4) begin hcount_in = '0; vcount_in = '0; end
            if (update_out) begin
                pulses_o++;
                if (lat_o == 0) lat_o = k;
            end
        end
    endtask

    task automatic frame(input string tag, input logic [4*XW-1:0] xv, input logic [4*YW-1:0] yv,
                         input logic [4*YW-1:0] dv, input logic [3:0] vv);
        int l, p;
        run_frame(xv, yv, dv, vv, 1'b0, l, p);
        check({tag, "_lat"}, l, 6);
        check({tag, "_pulses"}, p, 1);
    endtask

    initial begin
        rst_n_in = 1'b0;
        hcount_in = '0; vcount_in = '0;
        x_in = '0; y_in = '0; d_in = '0; valid_in = '0;
        repeat (3) @(negedge clk_in);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_d", d_out, 0);
        check("rst_locked", locked_out, 0);
        check("rst_update", update_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_state", state_out, 0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // fresh acquisition of target 0
        frame("t1", px(100,0,0,0), py(50,0,0,0), py(20,0,0,0), 4'b1000);
        check("t1_x", x_out, px(100,0,0,0));
        check("t1_y", y_out, py(50,0,0,0));
        check("t1_d", d_out, py(20,0,0,0));
        check("t1_locked", locked_out, 4'b0001);

        // smoothing, including negative steps rounding toward -inf
        frame("t2a", px(140,0,0,0), py(50,0,0,0), py(20,0,0,0), 4'b1000);
        check("t2a_x", x_out, px(110,0,0,0));
        frame("t2b", px(60,0,0,0), py(46,0,0,0), py(23,0,0,0), 4'b1000);
        check("t2b_x", x_out, px(97,0,0,0));
        check("t2b_y", y_out, py(49,0,0,0));
        check("t2b_d", d_out, py(20,0,0,0));

        // jump of exactly 64 accepted; diameter never jump-checked
        frame("t3a", px(161,0,0,0), py(49,0,0,0), py(200,0,0,0), 4'b1000);
        check("t3a_x", x_out, px(113,0,0,0));
        check("t3a_d", d_out, py(65,0,0,0));
        frame("t3b", px(178,0,0,0), py(49,0,0,0), py(65,0,0,0), 4'b1000);
        check("t3b_x", x_out, px(113,0,0,0));
        check("t3b_locked", locked_out, 4'b0001);
        frame("t3c", px(113,0,0,0), py(114,0,0,0), py(65,0,0,0), 4'b1000);
        check("t3c_y", y_out, py(49,0,0,0));
        for (int i = 0; i < 5; i++) frame("t3d", px(300,0,0,0), py(49,0,0,0), py(65,0,0,0), 4'b1000);
        check("t3d_locked7", locked_out, 4'b0001);
        check("t3d_x", x_out, px(113,0,0,0));
        frame("t3e", px(300,0,0,0), py(49,0,0,0), py(65,0,0,0), 4'b1000);
        check("t3e_locked8", locked_out, 4'b0000);
        check("t3e_x", x_out, px(113,0,0,0));
        check("t3e_y", y_out, py(49,0,0,0));
        check("t3e_d", d_out, py(65,0,0,0));

        // reacquire loads directly, no jump check while unlocked
        frame("t3f", px(500,0,0,0), py(300,0,0,0), py(40,0,0,0), 4'b1000);
        check("t3f_x", x_out, px(500,0,0,0));
        check("t3f_locked", locked_out, 4'b0001);

        // missed frames: 7 keep lock, a valid one resets the count, then 8 drop it
        for (int i = 0; i < 7; i++) frame("t4a", px(900,0,0,0), py(9,0,0,0), py(9,0,0,0), 4'b0000);
        check("t4a_locked", locked_out, 4'b0001);
        frame("t4b", px(504,0,0,0), py(300,0,0,0), py(40,0,0,0), 4'b1000);
        check("t4b_x", x_out, px(501,0,0,0));
        for (int i = 0; i < 7; i++) frame("t4c", px(900,0,0,0), py(9,0,0,0), py(9,0,0,0), 4'b0000);
        check("t4c_locked", locked_out, 4'b0001);
        frame("t4d", px(900,0,0,0), py(9,0,0,0), py(9,0,0,0), 4'b0000);
        check("t4d_locked", locked_out, 4'b0000);
        check("t4d_x", x_out, px(501,0,0,0));
        check("t4d_y", y_out, py(300,0,0,0));

        // all four targets, then a subset to exercise the valid bit order
        frame("m1", px(10,20,30,40), py(1,2,3,4), py(5,6,7,8), 4'b1111);
        check("m1_x", x_out, px(10,20,30,40));
        check("m1_y", y_out, py(1,2,3,4));
        check("m1_d", d_out, py(5,6,7,8));
        check("m1_locked", locked_out, 4'b1111);
        frame("m2", px(999,28,999,48), py(0,2,0,4), py(0,6,0,8), 4'b0101);
        check("m2_x", x_out, px(10,22,30,42));
        check("m2_y", y_out, py(1,2,3,4));
        check("m2_locked", locked_out, 4'b1111);

        // second frame end during the update is ignored
        run_frame(px(14,26,34,46), py(1,2,3,4), py(5,6,7,8), 4'b1111, 1'b1, lat, pulses);
        check("t5_lat", lat, 6);
        check("t5_pulses", pulses, 1);
        check("t5_x", x_out, px(11,23,31,43));
        check("t5_d", d_out, py(5,6,7,8));

        // reset two cycles after the frame end aborts the update
        @(negedge clk_in);
        x_in = px(700,0,0,0); y_in = py(70,0,0,0); d_in = py(7,0,0,0); valid_in = 4'b1000;
        hcount_in = H_LAST; vcount_in = V_LAST;
        @(negedge clk_in);
        hcount_in = '0; vcount_in = '0;
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        check("t6_x", x_out, 0);
        check("t6_locked", locked_out, 0);
        check("t6_busy", busy_out, 0);
        check("t6_state", state_out, 0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (update_out) pulses++;
        end
        check("t6_nopulse", pulses, 0);
        frame("t6b", px(100,0,0,0), py(50,0,0,0), py(20,0,0,0), 4'b1000);
        check("t6b_x", x_out, px(100,0,0,0));
        check("t6b_y", y_out, py(50,0,0,0));
        check("t6b_locked", locked_out, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
